// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core_if
//  Brief    : Byte output handshake and status strobes of the UART receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, busy, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, busy, frame_err, overrun, parity_err,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Brief    : 16x-oversampled UART receiver (8N1, or 8E1 when
//             UART_RX_PARITY_EN is defined) with a one-entry output register.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  wire            clk,
    input  wire            reset,
    input  wire            rx,
    uart_rx_core_if.master rx_if
);

    localparam int c_div   = CLK_FREQ / (BAUD * OVS);
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_smp_w = $clog2(OVS);
    localparam logic [c_cnt_w-1:0] c_tick_max = c_cnt_w'(c_div - 1);
    localparam logic [c_smp_w-1:0] c_smp_a    = c_smp_w'(OVS / 2 - 1);
    localparam logic [c_smp_w-1:0] c_smp_b    = c_smp_w'(OVS / 2);
    localparam logic [c_smp_w-1:0] c_smp_c    = c_smp_w'(OVS / 2 + 1);
    localparam logic [c_smp_w-1:0] c_smp_last = c_smp_w'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]           r_settle;
    logic                 r_armed;
    logic [c_cnt_w-1:0]   r_tick_cnt;
    logic [c_smp_w-1:0]   r_smp_cnt;
    logic                 r_s_a, r_s_b;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_fall, w_tick, w_vote;
    logic                 w_start, w_deliver, w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_parity_err;
    logic                 w_perr;
    logic                 w_par_bad;
    assign w_par_bad = ^{r_shift, r_par};
`endif

    // Edges are only trusted once the line has been seen idle after reset,
    // so a frame already in flight at reset release is not picked up.
    assign w_fall = r_armed & r_rx_prev & ~r_rx_sync;
    assign w_tick = (r_tick_cnt == c_tick_max);
    assign w_vote = (r_s_a & r_s_b) | (r_s_a & r_rx_sync) | (r_s_b & r_rx_sync);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_settle  <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            if (r_settle == 2'd3 && r_rx_sync) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick && r_smp_cnt == c_smp_a && r_rx_sync) w_state_nxt = S_IDLE;
                else if (w_tick && r_smp_cnt == c_smp_last)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_smp_cnt == c_smp_last && r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick && r_smp_cnt == c_smp_last) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick && r_smp_cnt == c_smp_c) begin
                    w_state_nxt = S_IDLE;
                    if (!w_vote)        w_ferr    = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (w_par_bad) w_perr    = 1'b1;
`endif
                    else                w_deliver = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_smp_cnt  <= '0;
            r_s_a      <= 1'b1;
            r_s_b      <= 1'b1;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            if (w_start || w_tick) r_tick_cnt <= '0;
            else                   r_tick_cnt <= r_tick_cnt + 1'b1;

            if (w_start) begin
                r_smp_cnt <= '0;
                r_bit_cnt <= 3'd0;
            end else if (w_tick) begin
                r_smp_cnt <= (r_smp_cnt == c_smp_last) ? '0 : r_smp_cnt + 1'b1;
                if (r_smp_cnt == c_smp_a) r_s_a <= r_rx_sync;
                if (r_smp_cnt == c_smp_b) r_s_b <= r_rx_sync;
                if (r_state == S_DATA && r_smp_cnt == c_smp_c)    r_shift   <= {w_vote, r_shift[7:1]};
                if (r_state == S_DATA && r_smp_cnt == c_smp_last) r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (r_state == S_PARITY && r_smp_cnt == c_smp_c)  r_par     <= w_vote;
`endif
            end
        end
    end

    // A byte arriving while the register is full is dropped unless the
    // consumer is taking the old one in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= w_ferr;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_perr;
`endif
            if (w_deliver) begin
                if (!r_rx_valid || rx_if.rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_rx_valid && rx_if.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_valid  = r_rx_valid;
    assign rx_if.busy      = (r_state != S_IDLE);
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = r_parity_err;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Brief    : Scoreboard bench for uart_rx_core at a scaled baud rate
//             (4 clk per sample, 64 clk per bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int OVS      = 16;
    localparam int BIT_CLK  = (CLK_FREQ / (BAUD * OVS)) * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA    = BIT_CLK;
`else
    localparam int EXTRA    = 0;
`endif
    localparam int LAT_LO   = 9 * BIT_CLK + EXTRA;
    localparam int LAT_HI   = 10 * BIT_CLK + BIT_CLK / 4 + EXTRA;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_core_if rx_if ();

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int t_start  = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0;
    int b_ferr = 0, b_ovr = 0, b_perr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        t_start = cycle;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clk(BIT_CLK);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        wait_clk(BIT_CLK);
        rx = 1'b1;
    endtask

    task automatic mark();
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
        b_perr = n_perr;
    endtask

    task automatic check_pulses(input string tag, input int ef, input int eo, input int ep);
        check({tag, "_frame_err_cycles"}, n_ferr - b_ferr, ef);
        check({tag, "_overrun_cycles"},   n_ovr  - b_ovr,  eo);
        check({tag, "_parity_err_cycles"}, n_perr - b_perr, ep);
    endtask

    task automatic pop_byte(input string tag);
        rx_if.rx_ready = 1'b1;
        wait_clk(1);
        rx_if.rx_ready = 1'b0;
        wait_clk(1);
        check({tag, "_valid_after_pop"}, rx_if.rx_valid, 1'b0);
    endtask

    // Monitor: counts status pulse cycles and scores every newly presented byte.
    initial begin : monitor
        logic prev_valid;
        logic prev_ready;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_if.frame_err)  n_ferr++;
            if (rx_if.overrun)    n_ovr++;
            if (rx_if.parity_err) n_perr++;
            if (rx_if.rx_valid && (!prev_valid || prev_ready)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", rx_if.rx_data);
                end else begin
                    logic [7:0] e;
                    int lat;
                    e   = exp_q.pop_front();
                    lat = cycle - t_start;
                    check("rx_data", rx_if.rx_data, e);
                    check("latency_in_window", (lat >= LAT_LO && lat <= LAT_HI), 1);
                end
            end
            prev_valid = rx_if.rx_valid;
            prev_ready = rx_if.rx_ready;
        end
    end

    initial begin : stimulus
        rx_if.rx_ready = 1'b0;
        wait_clk(5);
        check("rst_rx_data",    rx_if.rx_data,    8'h00);
        check("rst_rx_valid",   rx_if.rx_valid,   1'b0);
        check("rst_busy",       rx_if.busy,       1'b0);
        check("rst_frame_err",  rx_if.frame_err,  1'b0);
        check("rst_overrun",    rx_if.overrun,    1'b0);
        check("rst_parity_err", rx_if.parity_err, 1'b0);
        reset = 1'b0;
        wait_clk(10);

        // Single byte, consumer not ready
        mark();
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("b41_busy_after", rx_if.busy, 1'b0);
        check("b41_valid_held", rx_if.rx_valid, 1'b1);
        check("b41_queue_empty", exp_q.size(), 0);
        check_pulses("b41", 0, 0, 0);
        pop_byte("b41");

        // Start-bit glitch
        mark();
        rx = 1'b0;
        wait_clk(10);
        check("glitch_busy_rise", rx_if.busy, 1'b1);
        wait_clk(2);
        rx = 1'b1;
        wait_clk(18);
        check("glitch_busy_before_s7", rx_if.busy, 1'b1);
        wait_clk(30);
        check("glitch_busy_dropped", rx_if.busy, 1'b0);
        wait_clk(2 * BIT_CLK);
        check("glitch_no_valid", rx_if.rx_valid, 1'b0);
        check_pulses("glitch", 0, 0, 0);

        // Stop bit forced low
        mark();
        send_frame(8'h55, 1'b0, 1'b0);
        wait_clk(2 * BIT_CLK);
        check("ferr_no_valid", rx_if.rx_valid, 1'b0);
        check_pulses("ferr", 1, 0, 0);

        // Back-to-back, consumer stalled: second byte overruns
        mark();
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("ovr_data_retained", rx_if.rx_data, 8'h12);
        check("ovr_valid_held", rx_if.rx_valid, 1'b1);
        check_pulses("ovr", 0, 1, 0);
        pop_byte("ovr");

        // Back-to-back, consumer always ready
        mark();
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("rdy_valid_cleared", rx_if.rx_valid, 1'b0);
        check("rdy_queue_empty", exp_q.size(), 0);
        check_pulses("rdy", 0, 0, 0);
        rx_if.rx_ready = 1'b0;

        // Reset in bit 3 of 0xA5, released in bit 6 while the line is low
        mark();
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
        join_none
        wait_clk(4 * BIT_CLK + BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(3);
        check("mid_rst_rx_data",  rx_if.rx_data,  8'h00);
        check("mid_rst_rx_valid", rx_if.rx_valid, 1'b0);
        check("mid_rst_busy",     rx_if.busy,     1'b0);
        check("mid_rst_pulses",   {rx_if.frame_err, rx_if.overrun, rx_if.parity_err}, 3'b000);
        wait_clk(3 * BIT_CLK - 3);
        reset = 1'b0;
        wait fork;
        wait_clk(2 * BIT_CLK);
        check("post_rst_no_valid", rx_if.rx_valid, 1'b0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("post_rst_data", rx_if.rx_data, 8'h3C);
        check("post_rst_queue_empty", exp_q.size(), 0);
        check_pulses("post_rst", 0, 0, 0);
        pop_byte("post_rst");

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1
        mark();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("par_ok_valid", rx_if.rx_valid, 1'b1);
        check_pulses("par_ok", 0, 0, 0);
        pop_byte("par_ok");

        mark();
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("par_bad_no_valid", rx_if.rx_valid, 1'b0);
        check_pulses("par_bad", 0, 0, 1);
`endif

        wait_clk(BIT_CLK);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
